// File: rtl/flags_pkg.sv
// Shared constants and stack-operation encoding for the flag register
// and its shadow LIFO.
package flags_pkg;

  localparam int FLG_C_IDX = 0;
  localparam int FLG_Z_IDX = 1;

  typedef enum logic [1:0] {
    OP_NONE,
    OP_PUSH,
    OP_POP,
    OP_XCHG
  } stk_op_t;

endpackage

// File: rtl/flag_lifo.sv
// Shadow LIFO for saved flag words: entry storage, occupancy count and
// a combinational view of the current top entry.
module flag_lifo
  import flags_pkg::*;
#(
  parameter int W     = 2,
  parameter int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  stk_op_t          op,
  input  logic [W-1:0]     wr_data,
  output logic [W-1:0]     rd_top,
  output logic [CNT_W-1:0] cnt,
  output logic             empty,
  output logic             full
);

  logic [DEPTH-1:0][W-1:0] entries_q, entries_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  // Push writes the slot at cnt; exchange overwrites the live top at cnt-1.
  always_comb begin
    entries_d = entries_q;
    for (int i = 0; i < DEPTH; i++) begin
      if ((op == OP_PUSH) && (cnt_q == CNT_W'(i)))
        entries_d[i] = wr_data;
      if ((op == OP_XCHG) && (cnt_q == CNT_W'(i + 1)))
        entries_d[i] = wr_data;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    case (op)
      OP_PUSH: cnt_d = cnt_q + CNT_W'(1);
      OP_POP:  cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    rd_top = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (cnt_q == CNT_W'(i + 1))
        rd_top = entries_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      entries_q <= '0;
      cnt_q     <= '0;
    end else begin
      entries_q <= entries_d;
      cnt_q     <= cnt_d;
    end
  end

  assign cnt   = cnt_q;
  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CNT_W'(DEPTH));

endmodule

// File: rtl/flags_stack.sv
// Condition-flag register with per-bit set/clear/load and a nested
// save/restore shadow stack for interrupt entry and RETIE.
module flags_stack
  import flags_pkg::*;
#(
  parameter int N_FLAGS = 2,
  parameter int DEPTH   = 4,
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [N_FLAGS-1:0] FLG_SET,
  input  logic [N_FLAGS-1:0] FLG_CLR,
  input  logic [N_FLAGS-1:0] FLG_LD,
  input  logic [N_FLAGS-1:0] FLG_IN,
  input  logic               FLG_PUSH,
  input  logic               FLG_POP,
  input  logic               ERR_CLR,
  output logic [N_FLAGS-1:0] FLAGS_OUT,
  output logic [CNT_W-1:0]   STK_CNT,
  output logic               STK_EMPTY,
  output logic               STK_FULL,
  output logic               OVF_ERR,
  output logic               UNF_ERR
);

  logic [N_FLAGS-1:0] flags_q, flags_d;
  logic [N_FLAGS-1:0] bit_next;
  logic [N_FLAGS-1:0] rd_top;
  logic               ovf_q, ovf_d;
  logic               unf_q, unf_d;
  logic               ovf_evt, unf_evt;
  logic               stk_empty, stk_full;
  stk_op_t            op;

  // Pop from a non-empty stack takes precedence; push+pop on empty degrades to push.
  always_comb begin
    op      = OP_NONE;
    ovf_evt = 1'b0;
    unf_evt = 1'b0;
    if (FLG_POP && !stk_empty) begin
      op = FLG_PUSH ? OP_XCHG : OP_POP;
    end else begin
      if (FLG_POP)
        unf_evt = 1'b1;
      if (FLG_PUSH) begin
        if (!stk_full)
          op = OP_PUSH;
        else
          ovf_evt = 1'b1;
      end
    end
  end

  for (genvar gi = 0; gi < N_FLAGS; gi++) begin : g_bit
    assign bit_next[gi] = FLG_CLR[gi] ? 1'b0 :
                          FLG_SET[gi] ? 1'b1 :
                          FLG_LD[gi]  ? FLG_IN[gi] :
                                        flags_q[gi];
  end

  always_comb begin
    flags_d = bit_next;
    if ((op == OP_POP) || (op == OP_XCHG))
      flags_d = rd_top;
  end

  // A new error event in the same cycle beats ERR_CLR.
  always_comb begin
    ovf_d = ovf_q;
    unf_d = unf_q;
    if (ERR_CLR) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end
    if (ovf_evt)
      ovf_d = 1'b1;
    if (unf_evt)
      unf_d = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      flags_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      flags_q <= flags_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  flag_lifo #(
    .W     (N_FLAGS),
    .DEPTH (DEPTH)
  ) u_lifo (
    .clk     (CLK),
    .rst     (RST),
    .op      (op),
    .wr_data (flags_q),
    .rd_top  (rd_top),
    .cnt     (STK_CNT),
    .empty   (stk_empty),
    .full    (stk_full)
  );

  assign FLAGS_OUT = flags_q;
  assign STK_EMPTY = stk_empty;
  assign STK_FULL  = stk_full;
  assign OVF_ERR   = ovf_q;
  assign UNF_ERR   = unf_q;

endmodule

// File: tb/tb_flags_stack.sv
// Directed vector table plus randomized run against a queue-based model
// of the flag register and shadow stack.
module tb_flags_stack;

  localparam int NF = 2;
  localparam int D  = 4;
  localparam int CW = 3;

  logic          CLK = 1'b0;
  logic          RST;
  logic [NF-1:0] FLG_SET, FLG_CLR, FLG_LD, FLG_IN;
  logic          FLG_PUSH, FLG_POP, ERR_CLR;
  logic [NF-1:0] FLAGS_OUT;
  logic [CW-1:0] STK_CNT;
  logic          STK_EMPTY, STK_FULL, OVF_ERR, UNF_ERR;

  int checks = 0;
  int errors = 0;

  flags_stack #(.N_FLAGS(NF), .DEPTH(D)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .FLG_SET   (FLG_SET),
    .FLG_CLR   (FLG_CLR),
    .FLG_LD    (FLG_LD),
    .FLG_IN    (FLG_IN),
    .FLG_PUSH  (FLG_PUSH),
    .FLG_POP   (FLG_POP),
    .ERR_CLR   (ERR_CLR),
    .FLAGS_OUT (FLAGS_OUT),
    .STK_CNT   (STK_CNT),
    .STK_EMPTY (STK_EMPTY),
    .STK_FULL  (STK_FULL),
    .OVF_ERR   (OVF_ERR),
    .UNF_ERR   (UNF_ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic          rst;
    logic [NF-1:0] set, clr, ld, fin;
    logic          push, pop, eclr;
    logic [NF-1:0] e_flags;
    logic [CW-1:0] e_cnt;
    logic          e_ovf, e_unf;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input int rst, input int set, input int clr, input int ld,
                              input int fin, input int push, input int pop, input int eclr,
                              input int ef, input int ec, input int eo, input int eu);
    vec_t v;
    v.rst = 1'(rst);   v.set = NF'(set);  v.clr = NF'(clr); v.ld = NF'(ld);
    v.fin = NF'(fin);  v.push = 1'(push); v.pop = 1'(pop);  v.eclr = 1'(eclr);
    v.e_flags = NF'(ef); v.e_cnt = CW'(ec); v.e_ovf = 1'(eo); v.e_unf = 1'(eu);
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic [NF-1:0] set, input logic [NF-1:0] clr,
                       input logic [NF-1:0] ld, input logic [NF-1:0] fin,
                       input logic push, input logic pop, input logic eclr);
    RST = rst; FLG_SET = set; FLG_CLR = clr; FLG_LD = ld; FLG_IN = fin;
    FLG_PUSH = push; FLG_POP = pop; ERR_CLR = eclr;
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_all(input string tag, input int ef, input int ec, input int eo, input int eu);
    chk({tag, ".flags"}, int'(FLAGS_OUT), ef);
    chk({tag, ".cnt"},   int'(STK_CNT),   ec);
    chk({tag, ".empty"}, int'(STK_EMPTY), (ec == 0) ? 1 : 0);
    chk({tag, ".full"},  int'(STK_FULL),  (ec == D) ? 1 : 0);
    chk({tag, ".ovf"},   int'(OVF_ERR),   eo);
    chk({tag, ".unf"},   int'(UNF_ERR),   eu);
  endtask

  // Reference model: flags word, stack as a queue (back = top), sticky bits.
  logic [NF-1:0] m_flags;
  logic [NF-1:0] m_stk[$];
  logic          m_ovf, m_unf;

  task automatic model_step(input logic rst, input logic [NF-1:0] set, input logic [NF-1:0] clr,
                            input logic [NF-1:0] ld, input logic [NF-1:0] fin,
                            input logic push, input logic pop, input logic eclr);
    logic [NF-1:0] upd, top;
    logic oe, ue;
    if (rst) begin
      m_flags = '0; m_stk.delete(); m_ovf = 1'b0; m_unf = 1'b0;
      return;
    end
    upd = (((m_flags & ~ld) | (fin & ld)) | set) & ~clr;
    oe = 1'b0; ue = 1'b0;
    if (pop && m_stk.size() > 0) begin
      top = m_stk[m_stk.size() - 1];
      if (push) m_stk[m_stk.size() - 1] = m_flags;
      else      void'(m_stk.pop_back());
      m_flags = top;
    end else begin
      if (pop) ue = 1'b1;
      if (push) begin
        if (m_stk.size() < D) m_stk.push_back(m_flags);
        else oe = 1'b1;
      end
      m_flags = upd;
    end
    m_ovf = oe ? 1'b1 : (eclr ? 1'b0 : m_ovf);
    m_unf = ue ? 1'b1 : (eclr ? 1'b0 : m_unf);
  endtask

  initial begin
    RST = 1'b1; FLG_SET = '0; FLG_CLR = '0; FLG_LD = '0; FLG_IN = '0;
    FLG_PUSH = 1'b0; FLG_POP = 1'b0; ERR_CLR = 1'b0;

    //              rst set clr ld in push pop eclr | flags cnt ovf unf
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0));
    vecs.push_back(mk(0, 3, 0, 0, 0, 0, 0, 0,   3, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0,   2, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 3, 1, 0, 0, 0,   1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 3, 2, 1, 0, 0,   2, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0,   2, 2, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0,   2, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0,   1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 3, 3, 1, 0, 0,   3, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 3, 0, 1, 0, 0,   0, 2, 0, 0));
    vecs.push_back(mk(0, 0, 0, 3, 2, 1, 0, 0,   2, 3, 0, 0));
    vecs.push_back(mk(0, 0, 0, 3, 1, 1, 0, 0,   1, 4, 0, 0));
    vecs.push_back(mk(0, 2, 0, 0, 0, 1, 0, 0,   3, 4, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0,   2, 3, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0,   0, 2, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0,   3, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0,   1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1,   1, 0, 0, 0));
    vecs.push_back(mk(0, 3, 0, 0, 0, 0, 0, 0,   3, 0, 0, 0));
    vecs.push_back(mk(0, 0, 2, 0, 0, 0, 1, 0,   1, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1,   1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 3, 2, 0, 0, 0,   2, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 3, 1, 1, 0, 0,   1, 1, 0, 0));
    vecs.push_back(mk(0, 3, 0, 0, 0, 1, 1, 0,   2, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0,   1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0,   1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0,   1, 2, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0,   1, 3, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0,   1, 4, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0,   1, 4, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0,   1, 3, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0,   0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0,   0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1,   0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 0, 0, 0, 1, 1, 0,   1, 1, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0,   0, 0, 0, 1));

    foreach (vecs[k]) begin
      drive(vecs[k].rst, vecs[k].set, vecs[k].clr, vecs[k].ld, vecs[k].fin,
            vecs[k].push, vecs[k].pop, vecs[k].eclr);
      $display("vec %0d: push=%b pop=%b flags=%b cnt=%0d ovf=%b unf=%b",
               k, vecs[k].push, vecs[k].pop, FLAGS_OUT, STK_CNT, OVF_ERR, UNF_ERR);
      chk_all($sformatf("vec%0d", k), int'(vecs[k].e_flags), int'(vecs[k].e_cnt),
              int'(vecs[k].e_ovf), int'(vecs[k].e_unf));
    end

    // Hand sequence: exchange while full keeps count and raises no overflow.
    drive(1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    for (int p = 0; p < D; p++)
      drive(1'b0, 2'b00, 2'b00, 2'b11, NF'(p), 1'b1, 1'b0, 1'b0);
    drive(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0);
    $display("seq xchg_full: flags=%b cnt=%0d ovf=%b", FLAGS_OUT, STK_CNT, OVF_ERR);
    chk_all("xchg_full", 2, D, 0, 0);
    drive(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
    $display("seq xchg_pop: flags=%b cnt=%0d", FLAGS_OUT, STK_CNT);
    chk_all("xchg_pop", 3, D - 1, 0, 0);

    // Randomized run against the model; first cycle resets both sides.
    for (int n = 0; n < 400; n++) begin
      logic          r_rst, r_push, r_pop, r_eclr;
      logic [NF-1:0] r_set, r_clr, r_ld, r_in;
      r_rst  = (n == 0) || ($urandom_range(0, 59) == 0);
      r_set  = ($urandom_range(0, 3) == 0) ? NF'($urandom_range(0, 3)) : '0;
      r_clr  = ($urandom_range(0, 3) == 0) ? NF'($urandom_range(0, 3)) : '0;
      r_ld   = ($urandom_range(0, 1) == 0) ? NF'($urandom_range(0, 3)) : '0;
      r_in   = NF'($urandom_range(0, 3));
      r_push = ($urandom_range(0, 1) == 0);
      r_pop  = ($urandom_range(0, 2) == 0);
      r_eclr = ($urandom_range(0, 7) == 0);
      model_step(r_rst, r_set, r_clr, r_ld, r_in, r_push, r_pop, r_eclr);
      drive(r_rst, r_set, r_clr, r_ld, r_in, r_push, r_pop, r_eclr);
      $display("rnd %0d: rst=%b push=%b pop=%b flags=%b cnt=%0d ovf=%b unf=%b",
               n, r_rst, r_push, r_pop, FLAGS_OUT, STK_CNT, OVF_ERR, UNF_ERR);
      chk_all($sformatf("rnd%0d", n), int'(m_flags), m_stk.size(), int'(m_ovf), int'(m_unf));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
